// File: rtl/dac_out_pkg.sv
// Shared constants and FSM state type for the DAC output path.
// The command word is signed 16Q48 and the DAC code is offset binary.
package dac_out_pkg;

    localparam int          DEF_FLOAT_WIDTH = 64;
    localparam int          Q_POINT         = 48;
    localparam int          DEF_DAC_WIDTH   = 14;
    localparam logic [63:0] DEF_DAC_GAIN    = 64'h1FFF_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RAMP,
        ST_SETTLE
    } dac_state_t;

endpackage

// File: rtl/dac_out_slew_limiter.sv
// Moves the DAC code one bounded step toward its target.
// The result is combinational; the caller registers it.
module dac_slew_limiter #(
    parameter int DAC_WIDTH = 14,
    parameter int STEP      = 256
) (
    input  logic [DAC_WIDTH-1:0] current,
    input  logic [DAC_WIDTH-1:0] target,
    output logic [DAC_WIDTH-1:0] next_code
);

    localparam logic [DAC_WIDTH:0] STEP_W = (DAC_WIDTH+1)'(STEP);

    logic [DAC_WIDTH:0] dist_up;
    logic [DAC_WIDTH:0] dist_down;

    assign dist_up   = {1'b0, target} - {1'b0, current};
    assign dist_down = {1'b0, current} - {1'b0, target};

    // The addition and subtraction only happen when the distance exceeds STEP,
    // so they can never wrap past either end of the code range.
    always_comb begin
        next_code = target;
        if (target > current) begin
            if (dist_up > STEP_W) begin
                next_code = current + STEP_W[DAC_WIDTH-1:0];
            end
        end else if (target < current) begin
            if (dist_down > STEP_W) begin
                next_code = current - STEP_W[DAC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/dac_out.sv
// Turns a signed 16Q48 actuator command into a slew-limited offset-binary DAC code.
// After the code reaches its target and has settled, DONE pulses for one cycle.
module dac_out
    import dac_out_pkg::*;
#(
    parameter int                     FLOAT_WIDTH   = DEF_FLOAT_WIDTH,
    parameter int                     DAC_WIDTH     = DEF_DAC_WIDTH,
    parameter logic [FLOAT_WIDTH-1:0] DAC_GAIN      = DEF_DAC_GAIN,
    parameter int                     STEP          = 256,
    parameter int                     SETTLE_CYCLES = 16
) (
    input  logic                   DAC_CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic [FLOAT_WIDTH-1:0] DATA_IN,
    input  logic                   DATA_VALID,
    output logic                   READY,
    output logic [DAC_WIDTH-1:0]   DAC_DATA_OUT,
    output logic                   SAT,
    output logic                   DONE
);

    localparam int PW      = 2 * FLOAT_WIDTH;
    localparam int DAC_MID = 1 << (DAC_WIDTH - 1);
    localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DAC_WIDTH-1:0] CODE_MID    = DAC_WIDTH'(DAC_MID);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic signed [PW-1:0] WIDE_LO     = -(PW'(DAC_MID));
    localparam logic signed [PW-1:0] WIDE_HI     = PW'(DAC_MID - 1);

    dac_state_t state;
    dac_state_t state_next;

    logic [FLOAT_WIDTH-1:0] cmd_reg;
    logic [DAC_WIDTH-1:0]   target_code;
    logic [DAC_WIDTH-1:0]   slew_code;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   accept;
    logic                   done_next;

    logic signed [PW-1:0]   cmd_ext;
    logic signed [PW-1:0]   gain_ext;
    logic signed [PW-1:0]   product;
    logic signed [PW-1:0]   code_wide;
    logic [DAC_WIDTH-1:0]   clamp_code;
    logic                   clamp_sat;

    // The product of two Q48 operands carries 96 fractional bits; the arithmetic
    // shift floors it to whole code counts around mid-scale.
    assign cmd_ext   = {{FLOAT_WIDTH{cmd_reg[FLOAT_WIDTH-1]}}, cmd_reg};
    assign gain_ext  = {{FLOAT_WIDTH{DAC_GAIN[FLOAT_WIDTH-1]}}, DAC_GAIN};
    assign product   = cmd_ext * gain_ext;
    assign code_wide = product >>> (2 * Q_POINT);

    always_comb begin
        clamp_sat  = 1'b0;
        clamp_code = {~code_wide[DAC_WIDTH-1], code_wide[DAC_WIDTH-2:0]};
        if (code_wide < WIDE_LO) begin
            clamp_code = '0;
            clamp_sat  = 1'b1;
        end else if (code_wide > WIDE_HI) begin
            clamp_code = '1;
            clamp_sat  = 1'b1;
        end
    end

    dac_slew_limiter #(
        .DAC_WIDTH (DAC_WIDTH),
        .STEP      (STEP)
    ) u_slew (
        .current   (DAC_DATA_OUT),
        .target    (target_code),
        .next_code (slew_code)
    );

    assign accept = (state == ST_IDLE) && DATA_VALID && enable;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = enable ? ST_RAMP : ST_IDLE;
            end
            ST_RAMP: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (slew_code == target_code) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Dropping enable leaves the code and SAT where they are; only the state aborts.
    always_ff @(posedge DAC_CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            cmd_reg      <= '0;
            target_code  <= CODE_MID;
            DAC_DATA_OUT <= CODE_MID;
            settle_cnt   <= '0;
            READY        <= 1'b1;
            DONE         <= 1'b0;
            SAT          <= 1'b0;
        end else begin
            state <= state_next;
            READY <= (state_next == ST_IDLE);
            DONE  <= done_next;
            if (accept) begin
                cmd_reg <= DATA_IN;
            end
            if (state == ST_LOAD && enable) begin
                target_code <= clamp_code;
                SAT         <= clamp_sat;
            end
            if (state == ST_RAMP && enable) begin
                DAC_DATA_OUT <= slew_code;
            end
            if (state == ST_SETTLE && enable) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

endmodule
